// File: rtl/stream_fork_masked.sv
// Masked stream fork: one input beat is copied to the outputs selected by sel_i; latency 0 (OUP_REG=0) or 1 (OUP_REG=1).
// Backpressure: ready_o rises only once every selected output has taken the beat; early takers see valid drop until then.
module stream_fork_masked #(
    parameter int N_OUP      = 2,
    parameter int DATA_WIDTH = 8,
    parameter int OUP_REG    = 0
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        valid_i,
    output logic                        ready_o,
    input  logic [DATA_WIDTH-1:0]       data_i,
    input  logic [N_OUP-1:0]            sel_i,
    output logic [N_OUP-1:0]            valid_o,
    input  logic [N_OUP-1:0]            ready_i,
    output logic [N_OUP*DATA_WIDTH-1:0] data_o
);

    if (N_OUP < 1 || DATA_WIDTH < 1) begin : g_param_chk
        $fatal(1, "stream_fork_masked: N_OUP and DATA_WIDTH must be >= 1");
    end

    logic [N_OUP-1:0] done_q, done_d;
    logic [N_OUP-1:0] fork_vld;
    logic [N_OUP-1:0] oup_rdy;

    assign fork_vld = {N_OUP{valid_i}} & sel_i & ~done_q;
    assign ready_o  = valid_i & (&(~sel_i | done_q | oup_rdy));

    always_comb begin
        done_d = done_q | (fork_vld & oup_rdy);
        if (ready_o) begin
            done_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            done_q <= '0;
        end else begin
            done_q <= done_d;
        end
    end

    if (OUP_REG == 0) begin : g_comb
        assign oup_rdy = ready_i;
        assign valid_o = fork_vld;
        for (genvar i = 0; i < N_OUP; i++) begin : g_dat
            assign data_o[i*DATA_WIDTH +: DATA_WIDTH] = data_i;
        end
    end else begin : g_reg
        logic [N_OUP-1:0]            oq_valid_q, oq_valid_d;
        logic [N_OUP*DATA_WIDTH-1:0] oq_data_q;
        logic [N_OUP-1:0]            can_load;
        logic [N_OUP-1:0]            load;

        // Loading into a draining register keeps one beat per cycle.
        assign can_load   = ~oq_valid_q | ready_i;
        assign load       = fork_vld & can_load;
        assign oup_rdy    = can_load;
        assign oq_valid_d = load | (oq_valid_q & ~ready_i);

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                oq_valid_q <= '0;
            end else begin
                oq_valid_q <= oq_valid_d;
            end
        end

        // Payload has no reset; it simply holds across reset.
        always_ff @(posedge clk_i) begin
            for (int i = 0; i < N_OUP; i++) begin
                if (rst_ni && load[i]) begin
                    oq_data_q[i*DATA_WIDTH +: DATA_WIDTH] <= data_i;
                end
            end
        end

        assign valid_o = oq_valid_q;
        assign data_o  = oq_data_q;
    end

endmodule
